divider_seq: RTL

Sequential unsigned restoring divider that inverts the combinational small-width multiplier: given a W-bit dividend and W-bit divisor it produces quotient and remainder, one quotient bit per clock. It sits beside the multiplier in the arithmetic library and is used where area matters more than latency. Operands enter and results leave over valid/ready handshakes, so the block can be dropped between registered pipeline stages.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 34 +++
 rtl/divider_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_pkg;

    // Default operand/quotient/remainder width
    localparam int unsigned DIV_W = 4;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {R,Q} left by one, trial-subtract D,
// keep the difference and set the new quotient bit when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    output logic [W:0]   r_next,
    output logic [W-1:0] q_next
);

    logic [W:0]   r_sh;
    logic [W:0]   t;
    logic [W-1:0] q_sh;

    // Shift, trial subtract, restore on negative
    always_comb begin
        // r never exceeds W significant bits, so the bit shifted out of the top is always 0
        r_sh = (r << 1) | {{W{1'b0}}, q[W-1]};
        q_sh = {q[W-2:0], 1'b0};
        t    = r_sh - {1'b0, d};
        if (!t[W]) begin
            r_next = {1'b0, t[W-1:0]};
            q_next = q_sh | {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_next = r_sh;
            q_next = q_sh;
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with valid/ready
// handshakes on both the operand and the result side.
module divider_seq
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(W);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q;
    // Set once the final step has been applied; the following edge moves to DONE
    logic          last_q;
    logic [W:0]    r_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  d_q;
    logic          dbz_q;

    logic [W:0]    r_step;
    logic [W-1:0]  q_step;

    div_step #(
        .W (W)
    ) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_step),
        .q_next (q_step)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (last_q) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            last_q  <= 1'b0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        q_q     <= dividend;
                        d_q     <= divisor;
                        r_q     <= '0;
                        count_q <= CW'(W - 1);
                        last_q  <= 1'b0;
                        dbz_q   <= (divisor == '0);
                    end
                end
                CALC: begin
                    if (!last_q) begin
                        r_q <= r_step;
                        q_q <= q_step;
                        if (count_q == '0) begin
                            last_q <= 1'b1;
                        end else begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs depend on registered state only
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        quotient    = q_q;
        remainder   = r_q[W-1:0];
        div_by_zero = dbz_q;
    end

endmodule
